// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide into HI/LO.
// One operand bit per cycle; busy for WIDTH+1 cycles, done pulses when HI/LO are written.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_a;
    logic               r_sgn_pq;
    logic               r_sgn_r;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_sub;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_abs_a = (~op[0] & A[WIDTH-1]) ? -A : A;
    assign w_abs_b = (~op[0] & B[WIDTH-1]) ? -B : B;

    // Multiply: r_acc = {partial product, remaining multiplier bits}
    assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Divide: r_acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    // The non-borrow difference is always below the divisor, so a WIDTH-bit subtract suffices.
    assign w_shift  = {r_rem, r_acc[WIDTH-1]};
    assign w_borrow = w_shift < {1'b0, r_opnd};
    assign w_sub    = w_shift[WIDTH-1:0] - r_opnd;

    assign w_signed = ~r_op[0];
    assign w_prod   = (w_signed & r_sgn_pq) ? -r_acc : r_acc;
    assign w_quo    = r_div0 ? '1 :
                      (w_signed & r_sgn_pq) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_div0 ? r_a : (w_signed & r_sgn_r) ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_rem    <= '0;
            r_a      <= '0;
            r_sgn_pq <= 1'b0;
            r_sgn_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_a      <= A;
                        r_div0   <= (B == '0);
                        r_sgn_pq <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_sgn_r  <= A[WIDTH-1];
                        r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end else begin
                        if (hi_we) r_hi <= A;
                        if (lo_we) r_lo <= A;
                    end
                end
                CALC: begin
                    if (r_op[1]) begin
                        r_rem            <= w_borrow ? w_shift[WIDTH-1:0] : w_sub;
                        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_borrow};
                    end else begin
                        r_acc <= {w_add, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= FIN;
                end
                FIN: begin
                    if (r_op[1]) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: stimulus pushes expected HI/LO and done cycle,
// a monitor pops and compares on every done pulse.
module tb_mips_muldiv;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   done_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: model = 64'(sa * sb);
            2'd1: model = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) model = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) model = {a, 32'hFFFFFFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("result", {hi, lo}, e.res);
                check("latency", 64'(cyc), 64'(e.cyc));
                done_log.push_back(cyc);
            end
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge where done=1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        logic [31:0] h0, l0;
        exp_t        e;
        bit          ok;
        int          n;
        h0 = hi;
        l0 = lo;
        op = o;
        A = a;
        B = b;
        start = 1'b1;
        e.res = model(o, a, b);
        e.cyc = cyc + 34;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom);
        ok = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            if (!busy || hi !== h0 || lo !== l0) ok = 1'b0;
            if (disturb && n == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_and_hold", 64'(ok), 64'd1);
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        int          d1, d2;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(2'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("multu_const", {hi, lo}, 64'h00000002_FFFFFFFA);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        check("divu_const", {hi, lo}, 64'h00000002_0000000E);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'd3, 32'h12345678, 32'd0, 1'b0);
        check("divu_zero_const", {hi, lo}, 64'h12345678_FFFFFFFF);
        run_op(2'd2, 32'hFFFFFFF0, 32'd0, 1'b0);
        check("div_zero_const", {hi, lo}, 64'hFFFFFFF0_FFFFFFFF);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_wrap_const", {hi, lo}, 64'h00000000_80000000);

        @(negedge clk);
        hi_we = 1'b1;
        A = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'hDEADBEEF, 32'h80000000});
        lo_we = 1'b1;
        A = 32'h0BADF00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});

        run_op(2'd0, 32'h00012345, 32'hFFFF0003, 1'b1);

        run_op(2'd1, 32'd1000, 32'd2000, 1'b0);
        run_op(2'd3, 32'd2000, 32'd3, 1'b0);
        d2 = done_log[done_log.size()-1];
        d1 = done_log[done_log.size()-2];
        check("b2b_spacing", 64'(d2 - d1), 64'd34);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(o, a, b, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        op = 2'd1;
        A = 32'd5;
        B = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_result", {hi, lo}, 64'd0);
        run_op(2'd1, 32'd5, 32'd7, 1'b0);
        check("post_reset_multu", {hi, lo}, 64'd35);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
